// File: rtl/dispatch_router.sv
`default_nettype none
// ============================================================================
// dispatch_router: 2-entry in-order buffer routing decoded instructions to
// the INT / LS / BR issue queues, with flush and performance counters.
// Revision: 1.0
// ============================================================================
module dispatch_router #(
  parameter int TAG_W = 5,
  parameter int CNT_W = 32,
  parameter int STL_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    dec_valid,
  output logic                    dec_ready,
  input  logic [4:0]              dec_alu_ctrl,
  input  logic [2:0]              dec_inst_type,
  input  logic [8:0]              dec_flags,
  input  logic [TAG_W-1:0]        dec_rd,
  input  logic [TAG_W-1:0]        dec_rs1,
  input  logic [TAG_W-1:0]        dec_rs2,
  output logic [17+3*TAG_W-1:0]   disp_payload,
  output logic                    int_valid,
  input  logic                    int_ready,
  output logic                    ls_valid,
  input  logic                    ls_ready,
  output logic                    br_valid,
  input  logic                    br_ready,
  output logic [CNT_W-1:0]        disp_count,
  output logic [STL_W-1:0]        stall_cycles
);

  localparam int PW = 17 + 3*TAG_W;

  logic [PW-1:0]    mem_q [2];
  logic [PW-1:0]    mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic [CNT_W-1:0] disp_count_q, disp_count_d;
  logic [STL_W-1:0] stall_q, stall_d;

  logic [PW-1:0]    head;
  logic [8:0]       head_flags;
  logic             is_br, is_ls, has_head, sel_ready, push, pop;

  always_comb begin
    head       = mem_q[rd_ptr_q];
    head_flags = head[3*TAG_W +: 9];
    // flags = {Jump,JumpR,MemRead,MemWrite,ALUsrc,RegWrite,PCSave,BNE,BEQ}; branch class wins
    is_br      = head_flags[8] | head_flags[7] | head_flags[1] | head_flags[0];
    is_ls      = !is_br && (head_flags[6] | head_flags[5]);
    has_head   = (count_q != 2'd0) && !flush;

    int_valid    = has_head && !is_br && !is_ls;
    ls_valid     = has_head && is_ls;
    br_valid     = has_head && is_br;
    disp_payload = (count_q != 2'd0) ? head : '0;

    sel_ready = is_br ? br_ready : (is_ls ? ls_ready : int_ready);
    dec_ready = (count_q != 2'd2) && !flush;
    push      = dec_valid && dec_ready;
    pop       = has_head && sel_ready;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = {dec_alu_ctrl, dec_inst_type, dec_flags, dec_rd, dec_rs1, dec_rs2};
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    disp_count_d = disp_count_q + (pop ? CNT_W'(1) : CNT_W'(0));
    stall_d      = stall_q;
    if (has_head && !sel_ready && (stall_q != {STL_W{1'b1}})) begin
      stall_d = stall_q + STL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q[0]     <= '0;
      mem_q[1]     <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
      disp_count_q <= '0;
      stall_q      <= '0;
    end else begin
      mem_q[0]     <= mem_d[0];
      mem_q[1]     <= mem_d[1];
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      disp_count_q <= disp_count_d;
      stall_q      <= stall_d;
    end
  end

  assign disp_count   = disp_count_q;
  assign stall_cycles = stall_q;

endmodule
`default_nettype wire
